pcie_rx_credit: RTL and testbench

PCIE_RX_CREDIT -- requirements
Module: pcie_rx_credit

---
 rtl/pcie_rx_credit.sv | 128 ++++++++++++
 tb/tb_pcie_rx_credit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pcie_rx_credit.sv
// Receive-side flow-control credit return for VC0: tracks TLP framing, classifies
// each delivered TLP, and emits one-cycle credit pulses plus statistics counters.
module pcie_rx_credit #(
  parameter logic [7:0] PD_MAX = 8'd32
) (
  input  logic        clk_125,
  input  logic        rstn,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data,
  input  logic        rx_malf_tlp,
  output logic        ph_cr,
  output logic        pd_cr,
  output logic [7:0]  pd_num,
  output logic        nph_cr,
  output logic        npd_cr,
  output logic [15:0] cnt_p,
  output logic [15:0] cnt_np,
  output logic [15:0] cnt_cpl,
  output logic [15:0] cnt_drop,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR1 = 2'd1,
    BODY = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_fmt;
  logic [4:0]  r_type;
  logic [9:0]  r_len;
  logic        r_malf;

  logic        w_done, w_abandon;
  logic        w_posted, w_nonposted, w_cpl, w_malf, w_drop;
  logic [10:0] w_len11, w_dw;
  logic [7:0]  w_pd_num;
  logic        w_unused;

  assign w_unused    = rx_data[15];
  assign o_dbg_state = r_state;

  // rx_st always wins: it abandons whatever TLP was open and starts a new one.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_abandon   = 1'b0;
    if (rx_st) begin
      w_state_nxt = HDR1;
      w_abandon   = (r_state != IDLE);
    end else begin
      case (r_state)
        HDR1: w_state_nxt = BODY;
        BODY: begin
          if (rx_end) begin
            w_state_nxt = IDLE;
            w_done      = 1'b1;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      r_fmt  <= 2'd0;
      r_type <= 5'd0;
      r_len  <= 10'd0;
      r_malf <= 1'b0;
    end else if (rx_st) begin
      r_fmt  <= rx_data[14:13];
      r_type <= rx_data[12:8];
      r_malf <= rx_malf_tlp;
    end else if (r_state == HDR1) begin
      r_len  <= rx_data[9:0];
      r_malf <= r_malf | rx_malf_tlp;
    end else if (r_state == BODY) begin
      r_malf <= r_malf | rx_malf_tlp;
    end
  end

  // Classification uses the latched header; malf may still arrive on the rx_end word.
  assign w_posted    = ((r_type == 5'b00000) && r_fmt[1]) || (r_type[4:3] == 2'b10);
  assign w_nonposted = !w_posted &&
                       (((r_type[4:1] == 4'b0000) && !r_fmt[1]) ||
                        (r_type == 5'b00010) || (r_type == 5'b00100) || (r_type == 5'b00101));
  assign w_cpl       = (r_type == 5'b01010) || (r_type == 5'b01011);
  assign w_malf      = r_malf | rx_malf_tlp;
  assign w_drop      = w_abandon || (w_done && (w_malf || !(w_posted || w_nonposted || w_cpl)));

  // Length field of zero encodes 1024 DW; credits are one per 4 DW, rounded up.
  assign w_len11  = (r_len == 10'd0) ? 11'd1024 : {1'b0, r_len};
  assign w_dw     = (w_len11 + 11'd3) >> 2;
  assign w_pd_num = (w_dw > {3'b000, PD_MAX}) ? PD_MAX : w_dw[7:0];

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      ph_cr    <= 1'b0;
      pd_cr    <= 1'b0;
      pd_num   <= 8'd0;
      nph_cr   <= 1'b0;
      npd_cr   <= 1'b0;
      cnt_p    <= 16'd0;
      cnt_np   <= 16'd0;
      cnt_cpl  <= 16'd0;
      cnt_drop <= 16'd0;
    end else begin
      ph_cr  <= w_done && w_posted;
      pd_cr  <= w_done && w_posted && r_fmt[1];
      pd_num <= (w_done && w_posted && r_fmt[1]) ? w_pd_num : 8'd0;
      nph_cr <= w_done && w_nonposted;
      npd_cr <= w_done && w_nonposted && r_fmt[1];
      if (w_done && w_posted)    cnt_p    <= cnt_p + 16'd1;
      if (w_done && w_nonposted) cnt_np   <= cnt_np + 16'd1;
      if (w_done && w_cpl)       cnt_cpl  <= cnt_cpl + 16'd1;
      if (w_drop)                cnt_drop <= cnt_drop + 16'd1;
    end
  end

endmodule

// File: tb/tb_pcie_rx_credit.sv
// Bench for pcie_rx_credit: directed scenarios then random TLP traffic, checked
// every cycle against a TLP-level reference model.
module tb_pcie_rx_credit;

  localparam int PD_MAX_TB = 32;

  logic        clk_125 = 1'b0;
  logic        rstn;
  logic        rx_st, rx_end, rx_malf_tlp;
  logic [15:0] rx_data;
  logic        ph_cr, pd_cr, nph_cr, npd_cr;
  logic [7:0]  pd_num;
  logic [15:0] cnt_p, cnt_np, cnt_cpl, cnt_drop;
  logic [1:0]  w_dbg_state;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  bit          m_open;
  int          m_words;
  logic [1:0]  m_fmt;
  logic [4:0]  m_typ;
  logic [9:0]  m_len;
  bit          m_malf;
  logic        e_ph, e_pd, e_nph, e_npd;
  logic [7:0]  e_pdn;
  logic [15:0] c_p, c_np, c_cpl, c_drop;

  pcie_rx_credit #(.PD_MAX(8'd32)) dut (
    .clk_125(clk_125), .rstn(rstn),
    .rx_st(rx_st), .rx_end(rx_end), .rx_data(rx_data), .rx_malf_tlp(rx_malf_tlp),
    .ph_cr(ph_cr), .pd_cr(pd_cr), .pd_num(pd_num), .nph_cr(nph_cr), .npd_cr(npd_cr),
    .cnt_p(cnt_p), .cnt_np(cnt_np), .cnt_cpl(cnt_cpl), .cnt_drop(cnt_drop),
    .o_dbg_state(w_dbg_state)
  );

  always #4 clk_125 = ~clk_125;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ph_cr", {15'd0, ph_cr}, {15'd0, e_ph});
    chk("pd_cr", {15'd0, pd_cr}, {15'd0, e_pd});
    chk("pd_num", {8'd0, pd_num}, {8'd0, e_pdn});
    chk("nph_cr", {15'd0, nph_cr}, {15'd0, e_nph});
    chk("npd_cr", {15'd0, npd_cr}, {15'd0, e_npd});
    chk("cnt_p", cnt_p, c_p);
    chk("cnt_np", cnt_np, c_np);
    chk("cnt_cpl", cnt_cpl, c_cpl);
    chk("cnt_drop", cnt_drop, c_drop);
    e_ph = 0; e_pd = 0; e_nph = 0; e_npd = 0; e_pdn = 8'd0;
  endtask

  // A completed TLP: decide its class from the header rules and book the results.
  task automatic retire();
    bit posted, nonposted, cpl;
    int l, n;
    posted    = (m_typ == 5'd0 && m_fmt[1]) || (m_typ[4:3] == 2'b10);
    nonposted = !posted && ((m_typ <= 5'd1 && !m_fmt[1]) || m_typ == 5'd2 ||
                            m_typ == 5'd4 || m_typ == 5'd5);
    cpl       = (m_typ == 5'd10) || (m_typ == 5'd11);
    if (posted) begin
      e_ph = 1; c_p++;
      if (m_fmt[1]) begin
        l = (m_len == 10'd0) ? 1024 : int'(m_len);
        n = (l + 3) / 4;
        e_pd  = 1;
        e_pdn = 8'((n > PD_MAX_TB) ? PD_MAX_TB : n);
      end
    end
    if (nonposted) begin
      e_nph = 1; e_npd = m_fmt[1]; c_np++;
    end
    if (cpl) c_cpl++;
    if (m_malf || !(posted || nonposted || cpl)) c_drop++;
  endtask

  task automatic model_word(input logic st, input logic en, input logic [15:0] d, input logic m);
    if (st) begin
      if (m_open) c_drop++;
      m_open = 1; m_words = 1;
      m_fmt = d[14:13]; m_typ = d[12:8]; m_malf = m;
    end else if (m_open) begin
      m_malf = m_malf | m;
      if (m_words == 1) begin
        m_len = d[9:0]; m_words = 2;
      end else if (en) begin
        m_open = 0;
        retire();
      end
    end
  endtask

  task automatic step(input logic st, input logic en, input logic [15:0] d, input logic m);
    rx_st = st; rx_end = en; rx_data = d; rx_malf_tlp = m;
    model_word(st, en, d, m);
    @(negedge clk_125);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                          input int nbody, input int malf_idx);
    int total;
    logic [15:0] d;
    total = 2 + nbody;
    for (int i = 0; i < total; i++) begin
      if (i == 0)      d = {1'b0, fmt, typ, 8'h00};
      else if (i == 1) d = {6'd0, len};
      else             d = 16'($urandom);
      step(i == 0, i == total - 1, d, i == malf_idx);
    end
  endtask

  task automatic pulse_reset();
    rstn = 1'b0; rx_st = 0; rx_end = 0; rx_malf_tlp = 0;
    #1;
    m_open = 0; m_words = 0; m_malf = 0;
    c_p = 0; c_np = 0; c_cpl = 0; c_drop = 0;
    e_ph = 0; e_pd = 0; e_nph = 0; e_npd = 0; e_pdn = 8'd0;
    check_outputs();
    @(negedge clk_125);
    rstn = 1'b1;
  endtask

  initial begin
    logic [1:0] fmt;
    logic [4:0] typ;
    logic [9:0] len;
    int nb, mi;
    rstn = 1'b1; rx_st = 0; rx_end = 0; rx_data = 16'd0; rx_malf_tlp = 0;
    @(negedge clk_125);
    pulse_reset();
    idle(2);

    // MWr len=10 -> ph, pd, pd_num=3
    send_tlp(2'b10, 5'd0, 10'd10, 5, -1);
    idle(1);
    // MRd then CfgWr0
    send_tlp(2'b00, 5'd0, 10'd1, 1, -1);
    idle(1);
    send_tlp(2'b10, 5'd4, 10'd1, 2, -1);
    idle(1);
    // MWr len=0 clamps to PD_MAX; CplD no pulses
    send_tlp(2'b10, 5'd0, 10'd0, 3, -1);
    send_tlp(2'b10, 5'd10, 10'd4, 2, -1);
    idle(2);
    // stray rx_end in IDLE, and rx_end on the length word, are ignored
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h4000, 1'b0);
    step(1'b0, 1'b1, 16'h0008, 1'b0);
    step(1'b0, 1'b0, 16'h1234, 1'b0);
    step(1'b0, 1'b1, 16'h5678, 1'b0);
    idle(1);
    // abandon mid-BODY, then a complete MRd
    step(1'b1, 1'b0, 16'h4000, 1'b0);
    step(1'b0, 1'b0, 16'h0010, 1'b0);
    step(1'b0, 1'b0, 16'hAAAA, 1'b0);
    send_tlp(2'b00, 5'd0, 10'd1, 1, -1);
    idle(1);
    // four back-to-back MWr of 8 DW, then MWr flagged malformed
    for (int k = 0; k < 4; k++) send_tlp(2'b10, 5'd0, 10'd8, 8, -1);
    send_tlp(2'b11, 5'd0, 10'd16, 4, 3);
    idle(2);
    // reset while in HDR1; stale words must not produce a pulse
    step(1'b1, 1'b0, 16'h4000, 1'b0);
    pulse_reset();
    step(1'b0, 1'b0, 16'h0004, 1'b0);
    step(1'b0, 1'b0, 16'hBEEF, 1'b0);
    step(1'b0, 1'b1, 16'hCAFE, 1'b0);
    send_tlp(2'b00, 5'd0, 10'd1, 1, -1);
    send_tlp(2'b10, 5'd0, 10'd100, 2, -1);
    idle(1);

    // randomized traffic
    for (int t = 0; t < 200; t++) begin
      fmt = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: typ = 5'd0;
        1: typ = 5'd1;
        2: typ = 5'd2;
        3: typ = 5'($urandom_range(4, 5));
        4: typ = 5'($urandom_range(16, 23));
        5: typ = 5'($urandom_range(10, 11));
        default: typ = 5'($urandom_range(0, 31));
      endcase
      len = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      nb  = $urandom_range(1, 4);
      mi  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb + 1) : -1;
      if ($urandom_range(0, 7) == 0) begin
        step(1'b1, 1'b0, {1'b0, fmt, typ, 8'h00}, 1'b0);
        if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, {6'd0, len}, 1'b0);
      end else begin
        send_tlp(fmt, typ, len, nb, mi);
      end
      if ($urandom_range(0, 7) == 0) step(1'b0, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
